// File: rtl/adsr_gain_controller_pkg.sv
// Shared envelope definitions: state encodings used by the ADSR controller,
// the Gain stage and the voice logic.
package adsr_gain_controller_pkg;

    typedef logic [2:0] env_state_t;

    localparam env_state_t IDLE    = 3'd0;
    localparam env_state_t ATTACK  = 3'd1;
    localparam env_state_t DECAY   = 3'd2;
    localparam env_state_t SUSTAIN = 3'd3;
    localparam env_state_t RELEASE = 3'd4;

    localparam int GAIN_W_DEFAULT = 8;
    localparam int RATE_W_DEFAULT = 16;

endpackage

// File: rtl/adsr_gain_controller_env_rate_counter.sv
// Sample-tick prescaler: emits one step every (rate+1) ticks. The rate is
// compared live, so lowering it mid-count fires on the very next tick.
module env_rate_counter #(
    parameter int RATE_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              clear,
    input  logic [RATE_W-1:0] rate,
    output logic              step
);

    logic [RATE_W-1:0] cnt;
    logic              due;

    assign due  = (cnt >= rate);
    assign step = tick & ~clear & due;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (tick) begin
            if (due) cnt <= '0;
            else     cnt <= cnt + RATE_W'(1);
        end
    end

endmodule

// File: rtl/adsr_gain_controller.sv
// ADSR envelope sequencer producing the registered gain word for the Gain stage.
//
//   state   | meaning
//   IDLE    | silent, gain held at 0, waiting for gate rise
//   ATTACK  | ramp up from current gain toward full scale
//   DECAY   | ramp down toward sustain_level
//   SUSTAIN | gain tracks sustain_level while gate is held
//   RELEASE | ramp down to 0 after gate fall
module adsr_gain_controller
    import adsr_gain_controller_pkg::*;
#(
    parameter int GAIN_W = GAIN_W_DEFAULT,
    parameter int RATE_W = RATE_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_tick,
    input  logic              gate,
    input  logic [RATE_W-1:0] attack_rate,
    input  logic [RATE_W-1:0] decay_rate,
    input  logic [RATE_W-1:0] release_rate,
    input  logic [GAIN_W-1:0] sustain_level,
    output logic [GAIN_W-1:0] gain_out,
    output logic [2:0]        env_state,
    output logic              active
);

    localparam logic [GAIN_W-1:0] GAIN_MAX = '1;
    localparam logic [GAIN_W-1:0] GAIN_ONE = GAIN_W'(1);

    env_state_t        state;
    logic [GAIN_W-1:0] gain;
    logic              gate_q;
    logic              rise;
    logic              fall;
    logic              edge_hit;
    logic              cnt_clear;
    logic              step;
    logic [RATE_W-1:0] rate_sel;
    logic [GAIN_W-1:0] gain_dec;

    assign rise     = gate & ~gate_q;
    assign fall     = ~gate & gate_q;
    assign edge_hit = rise | (fall & (state != IDLE));
    assign gain_dec = gain - GAIN_ONE;

    // Non-ramping states keep the counter parked so every ramp starts from zero.
    assign cnt_clear = edge_hit | (state == IDLE) | (state == SUSTAIN);

    always_comb begin
        rate_sel = '0;
        case (state)
            ATTACK:  rate_sel = attack_rate;
            DECAY:   rate_sel = decay_rate;
            RELEASE: rate_sel = release_rate;
            default: rate_sel = '0;
        endcase
    end

    env_rate_counter #(.RATE_W(RATE_W)) u_rate (
        .clk   (clk),
        .reset (reset),
        .tick  (sample_tick),
        .clear (cnt_clear),
        .rate  (rate_sel),
        .step  (step)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            gain   <= '0;
            gate_q <= 1'b0;
        end else begin
            gate_q <= gate;
            // Retrigger keeps the current gain so the attack never clicks.
            if (rise) begin
                state <= ATTACK;
            end else if (fall && state != IDLE) begin
                state <= RELEASE;
            end else begin
                case (state)
                    IDLE: gain <= '0;
                    ATTACK: begin
                        if (gain == GAIN_MAX) begin
                            state <= DECAY;
                        end else if (step) begin
                            gain <= gain + GAIN_ONE;
                            if (gain == GAIN_MAX - GAIN_ONE) state <= DECAY;
                        end
                    end
                    DECAY: begin
                        if (gain <= sustain_level) begin
                            state <= SUSTAIN;
                            gain  <= sustain_level;
                        end else if (step) begin
                            if (gain_dec <= sustain_level) begin
                                state <= SUSTAIN;
                                gain  <= sustain_level;
                            end else begin
                                gain <= gain_dec;
                            end
                        end
                    end
                    SUSTAIN: gain <= sustain_level;
                    RELEASE: begin
                        if (gain == '0) begin
                            state <= IDLE;
                        end else if (step) begin
                            gain <= gain_dec;
                            if (gain == GAIN_ONE) state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        gain  <= '0;
                    end
                endcase
            end
        end
    end

    assign gain_out  = gain;
    assign env_state = state;
    assign active    = (state != IDLE);

endmodule

// File: tb/tb_adsr_gain_controller.sv
// Directed bench for the ADSR gain controller with hand-computed expectations.
module tb_adsr_gain_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_tick;
    logic        gate;
    logic [15:0] attack_rate;
    logic [15:0] decay_rate;
    logic [15:0] release_rate;
    logic [7:0]  sustain_level;
    logic [7:0]  gain_out;
    logic [2:0]  env_state;
    logic        active;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] S_IDLE = 3'd0, S_ATT = 3'd1, S_DEC = 3'd2,
                           S_SUS = 3'd3, S_REL = 3'd4;

    adsr_gain_controller dut (
        .clk           (clk),
        .reset         (reset),
        .sample_tick   (sample_tick),
        .gate          (gate),
        .attack_rate   (attack_rate),
        .decay_rate    (decay_rate),
        .release_rate  (release_rate),
        .sustain_level (sustain_level),
        .gain_out      (gain_out),
        .env_state     (env_state),
        .active        (active)
    );

    always #5 clk = ~clk;

    task automatic clk_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_env(input string tag, input logic [7:0] g, input logic [2:0] s);
        chk({tag, "_gain"}, gain_out, g);
        chk({tag, "_state"}, {5'd0, env_state}, {5'd0, s});
        chk({tag, "_active"}, {7'd0, active}, {7'd0, (s != S_IDLE)});
    endtask

    initial begin
        reset = 1'b1; sample_tick = 1'b1; gate = 1'b0;
        attack_rate = 16'd0; decay_rate = 16'd1; release_rate = 16'd3;
        sustain_level = 8'h80;
        clk_n(2);
        reset = 1'b0;
        chk_env("reset", 8'h00, S_IDLE);

        // Attack at rate 0: one step per tick up to full scale, then DECAY
        gate = 1'b1;
        clk_n(1);
        chk_env("att_entry", 8'h00, S_ATT);
        clk_n(1);
        chk_env("att_first", 8'h01, S_ATT);
        clk_n(253);
        chk_env("att_fe", 8'hFE, S_ATT);
        clk_n(1);
        chk_env("att_top", 8'hFF, S_DEC);

        // Decay at rate 1: one step every 2 ticks down to sustain 0x80
        clk_n(1);
        chk_env("dec_1", 8'hFF, S_DEC);
        clk_n(1);
        chk_env("dec_2", 8'hFE, S_DEC);
        clk_n(251);
        chk_env("dec_81", 8'h81, S_DEC);
        clk_n(1);
        chk_env("dec_sus", 8'h80, S_SUS);
        sustain_level = 8'h90;
        clk_n(1);
        chk_env("sus_track", 8'h90, S_SUS);

        // Release at rate 3: one step every 4 ticks down to 0
        gate = 1'b0;
        clk_n(1);
        chk_env("rel_entry", 8'h90, S_REL);
        clk_n(3);
        chk_env("rel_3", 8'h90, S_REL);
        clk_n(1);
        chk_env("rel_4", 8'h8F, S_REL);
        clk_n(571);
        chk_env("rel_01", 8'h01, S_REL);
        clk_n(1);
        chk_env("rel_idle", 8'h00, S_IDLE);
        clk_n(3);
        chk_env("idle_hold", 8'h00, S_IDLE);

        // Retrigger from RELEASE keeps the current gain
        gate = 1'b1;
        clk_n(1);
        chk_env("att2_entry", 8'h00, S_ATT);
        clk_n(48);
        chk_env("att2_30", 8'h30, S_ATT);
        gate = 1'b0;
        clk_n(1);
        chk_env("rel2_entry", 8'h30, S_REL);
        gate = 1'b1;
        clk_n(1);
        chk_env("retrig", 8'h30, S_ATT);
        clk_n(1);
        chk_env("retrig_step", 8'h31, S_ATT);

        // No ticks: gain frozen, gate edges still move the state
        sample_tick = 1'b0;
        clk_n(10);
        chk_env("frozen", 8'h31, S_ATT);
        gate = 1'b0;
        clk_n(1);
        chk_env("frozen_fall", 8'h31, S_REL);
        clk_n(4);
        chk_env("frozen_rel", 8'h31, S_REL);
        gate = 1'b1;
        clk_n(1);
        chk_env("frozen_rise", 8'h31, S_ATT);

        // Live rate change: lowering the rate mid-count steps on the next tick
        attack_rate = 16'd100;
        sample_tick = 1'b1;
        clk_n(5);
        chk_env("slow_att", 8'h31, S_ATT);
        attack_rate = 16'd0;
        clk_n(1);
        chk_env("rate_drop", 8'h32, S_ATT);

        // Reset mid-attack at 0x40
        clk_n(14);
        chk_env("pre_reset", 8'h40, S_ATT);
        reset = 1'b1;
        gate  = 1'b0;
        clk_n(1);
        chk_env("mid_reset", 8'h00, S_IDLE);
        reset = 1'b0;
        clk_n(1);
        chk_env("post_reset", 8'h00, S_IDLE);

        // sustain_level at full scale: DECAY collapses straight into SUSTAIN
        sustain_level = 8'hFF;
        gate = 1'b1;
        clk_n(256);
        chk_env("full_top", 8'hFF, S_DEC);
        clk_n(1);
        chk_env("full_sus", 8'hFF, S_SUS);

        // Re-entering ATTACK already at full scale goes straight to DECAY
        gate = 1'b0;
        clk_n(1);
        chk_env("full_rel", 8'hFF, S_REL);
        gate = 1'b1;
        clk_n(1);
        chk_env("full_att", 8'hFF, S_ATT);
        clk_n(1);
        chk_env("full_att_dec", 8'hFF, S_DEC);
        clk_n(1);
        chk_env("full_att_sus", 8'hFF, S_SUS);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
